div_seq: RTL
============

# div_seq

Multi-cycle unsigned restoring divider for the ALU datapath. It computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using a trial subtraction (A + ~B + 1) each cycle. It sits beside the combinational add/sub chain as the ALU's iterative divide unit, with a start/done handshake toward the ALU control.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  numerator; sampled with accepted start
- divisor  in  WIDTH  denominator; sampled with accepted start
- busy  out  1  high in RUN and DONE states
- done  out  1  one-cycle pulse; results valid in that cycle
- quotient  out  WIDTH  registered quotient
- remainder  out  WIDTH  registered remainder
- div_zero  out  1  registered; set when the accepted divisor was 0

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch divisor; load partial remainder R (WIDTH+1 bits) = 0 and Q = dividend; load counter = WIDTH.
  - If divisor == 0, go to DONE directly: quotient = all ones, remainder = dividend, div_zero = 1.
  - Otherwise clear div_zero and go to RUN.
- RUN, each cycle:
  - Shift {R,Q} left by one.
  - Compute T = R_shifted − {0,divisor} in WIDTH+1 bits.
  - If T's MSB is 0 (no borrow), R = T and Q[0] = 1. Otherwise R keeps the shifted value and Q[0] = 0.
  - Decrement counter. When the counter reaches 1, this is the last iteration; go to DONE on the next edge.
- DONE: assert done. quotient = Q and remainder = R[WIDTH−1:0]. Return to IDLE on the next edge.
- Held results: quotient, remainder and div_zero keep their values from DONE until the next accepted start. Accepting a start does not clear them; they update only on entry to DONE.
- start is ignored outside IDLE. A start that is high during the DONE cycle is not accepted. It must be high in IDLE to be accepted.
- Operand changes are ignored after acceptance.
- Invariant on completion with divisor ≠ 0: dividend = quotient·divisor + remainder, and remainder < divisor.

## Timing

- Reset values (rst_n low, asynchronous):
  - state = IDLE
  - busy = 0, done = 0
  - quotient = 0, remainder = 0, div_zero = 0
  - counter = 0
- Reset mid-operation: the calculation is aborted immediately. Outputs return to reset values and no done pulse follows.
- Cycle numbering: cycle 0 is the cycle in which start is sampled high in IDLE.
- Normal latency:
  - Cycles 1..WIDTH are RUN.
  - done = 1 in cycle WIDTH+1, so start-to-done = WIDTH+1 cycles (9 for WIDTH=8).
  - busy = 1 in cycles 1..WIDTH+1.
- Divide-by-zero latency: done = 1 in cycle 1; busy = 1 in cycle 1 only.
- Back-to-back throughput:
  - The earliest next accepted start is the cycle after done (IDLE).
  - Minimum period is WIDTH+2 cycles, or 2 cycles for divide-by-zero.
- done is exactly one cycle wide and never asserts without a preceding accepted start.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- **Basic divide:** WIDTH=8, dividend=100, divisor=7, start for 1 cycle → done in cycle 9 with quotient=14, remainder=2, div_zero=0; busy high in cycles 1–9.
- **Boundary operands:**
  - 255/1 → quotient=255, remainder=0.
  - 255/255 → quotient=1, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 0/3 → quotient=0, remainder=0.
- **Divide by zero:** 37/0 → done in cycle 1, quotient=0xFF, remainder=37, div_zero=1. A following 20/4 clears div_zero and gives quotient=5, remainder=0.
- **Start while busy / ignored operands:**
  - Start 100/7, then pulse start with 50/5 in cycle 4 → only one done (cycle 9), result 14 r 2.
  - start held high continuously → accepted in the first IDLE cycle after done; a new done follows every 10 cycles.
- **Reset mid-run:** drop rst_n in cycle 5 of 200/3 → outputs go to 0 immediately (asynchronously), no done. After release, 200/3 → quotient=66, remainder=2 in cycle 9.
- **Random regression:** 1000 random 8-bit pairs (divisor≠0) → check quotient·divisor + remainder = dividend and remainder < divisor. Results must hold stable until the next start.

Source files
------------

// File: rtl/div_seq_if.sv
// Start/done handshake and operand/result bundle between the ALU control
// (master) and the iterative divider (slave).
interface div_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a
// trial subtraction, with a start/done handshake and held registered results.
module div_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic       clk,
    input logic       rst_n,
    div_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             dz_in;
    logic             last;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             busy_nx;
    logic             done_nx;

    assign accept = (state == IDLE) && bus.start;
    assign dz_in  = (bus.divisor == '0);
    assign last   = (state == RUN) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = dz_in ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // busy/done are decoded from the next state and then registered, so both
    // line up with the state they describe without a comb path to the port.
    always_comb begin
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    // The partial remainder is kept in WIDTH bits: whenever the trial borrows,
    // the shifted value is below the divisor, so its top bit is always zero.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted + ~{1'b0, dvs} + ONE;
        if (!trial[WIDTH]) begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs           <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div_zero  <= 1'b0;
        end else begin
            bus.busy <= busy_nx;
            bus.done <= done_nx;
            if (accept) begin
                dvs <= bus.divisor;
                rem <= '0;
                quo <= bus.dividend;
                cnt <= CW'(WIDTH);
                if (dz_in) begin
                    bus.quotient  <= '1;
                    bus.remainder <= bus.dividend;
                    bus.div_zero  <= 1'b1;
                end
            end else if (state == RUN) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt - CW'(1);
                if (last) begin
                    bus.quotient  <= quo_nx;
                    bus.remainder <= rem_nx;
                    bus.div_zero  <= 1'b0;
                end
            end
        end
    end
endmodule
